// File: rtl/instr_loader_pkg.sv
// Shared definitions for the UART instruction loader: FSM states and frame constants.
`default_nettype none

package instr_loader_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LEN  = 3'd1,
      DATA = 3'd2,
      SUM  = 3'd3,
      DONE = 3'd4
   } state_t;

   localparam int CNT_W = 9;
   localparam int SUM_W = 8;
   localparam logic [CNT_W-1:0] LEN_ZERO_COUNT = 9'd256;

   // A length byte of zero stands for a full 256-byte payload.
   function automatic logic [CNT_W-1:0] frame_len(input logic [7:0] len_byte);
      return (len_byte == 8'd0) ? LEN_ZERO_COUNT : {1'b0, len_byte};
   endfunction

endpackage

`default_nettype wire

// File: rtl/instr_loader.sv
// Receives a length/payload/checksum frame from a UART byte stream and writes the
// payload into instruction memory, holding the CPU in reset until a good load completes.
`default_nettype none

module instr_loader
   import instr_loader_pkg::*;
#(
   parameter logic [7:0] BASE_ADDR = 8'h00
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       start,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       rx_ready,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_w_data,
   output logic       mem_w_en,
   output logic       cpu_hold,
   output logic       busy,
   output logic       done,
   output logic       err
);

   state_t           state;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] length;
   logic [SUM_W-1:0] checksum;
   logic             accept;

   assign busy     = (state == LEN) || (state == DATA) || (state == SUM);
   assign rx_ready = busy;
   assign accept   = rx_valid && rx_ready;
   // The CPU is released only once a load has finished with a matching checksum.
   assign cpu_hold = ~done;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state      <= IDLE;
         count      <= '0;
         length     <= '0;
         checksum   <= '0;
         mem_w_en   <= 1'b0;
         mem_addr   <= BASE_ADDR;
         mem_w_data <= 8'd0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         mem_w_en <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state    <= LEN;
                  done     <= 1'b0;
                  err      <= 1'b0;
                  checksum <= '0;
                  count    <= '0;
               end
            end
            LEN: begin
               if (accept) begin
                  length <= frame_len(rx_data);
                  count  <= '0;
                  state  <= DATA;
               end
            end
            DATA: begin
               if (accept) begin
                  mem_w_en   <= 1'b1;
                  mem_addr   <= BASE_ADDR + count[7:0];
                  mem_w_data <= rx_data;
                  checksum   <= checksum + rx_data;
                  count      <= count + 9'd1;
                  if (count == length - 9'd1) begin
                     state <= SUM;
                  end
               end
            end
            SUM: begin
               if (accept) begin
                  done  <= (rx_data == checksum);
                  err   <= (rx_data != checksum);
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_instr_loader.sv
// Directed self-checking bench for instr_loader: two instances (base 00 and base FE) share stimulus.
`default_nettype none

module tb_instr_loader;
   import instr_loader_pkg::*;

   logic       clock = 1'b0;
   logic       reset_n, start, rx_valid;
   logic [7:0] rx_data;

   logic       rx_ready0, mem_w_en0, cpu_hold0, busy0, done0, err0;
   logic [7:0] mem_addr0, mem_w_data0;
   logic       rx_ready1, mem_w_en1, cpu_hold1, busy1, done1, err1;
   logic [7:0] mem_addr1, mem_w_data1;

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;
   int last_acc, first_acc;

   logic [7:0] wa0[$];
   logic [7:0] wd0[$];
   int         wc0[$];
   logic [7:0] wa1[$];
   logic [7:0] pay_q[$];

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   instr_loader #(.BASE_ADDR(8'h00)) dut0 (
      .clock(clock), .reset_n(reset_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready0), .mem_addr(mem_addr0), .mem_w_data(mem_w_data0), .mem_w_en(mem_w_en0),
      .cpu_hold(cpu_hold0), .busy(busy0), .done(done0), .err(err0));

   instr_loader #(.BASE_ADDR(8'hFE)) dut1 (
      .clock(clock), .reset_n(reset_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready1), .mem_addr(mem_addr1), .mem_w_data(mem_w_data1), .mem_w_en(mem_w_en1),
      .cpu_hold(cpu_hold1), .busy(busy1), .done(done1), .err(err1));

   // Record every memory write seen between clock edges.
   always @(negedge clock) begin
      if (mem_w_en0) begin
         wa0.push_back(mem_addr0);
         wd0.push_back(mem_w_data0);
         wc0.push_back(cyc);
      end
      if (mem_w_en1) wa1.push_back(mem_addr1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic clear_log();
      wa0.delete(); wd0.delete(); wc0.delete(); wa1.delete();
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   // Present one byte (after an optional idle gap) and hold it until accepted.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int waitc;
      rx_valid = 1'b0;
      repeat (gap) @(negedge clock);
      rx_valid = 1'b1;
      rx_data  = b;
      waitc    = 0;
      while (!rx_ready0 && waitc < 20) begin
         @(negedge clock);
         waitc++;
      end
      if (!rx_ready0) check("rx_ready_timeout", 32'd0, 32'd1);
      last_acc = cyc + 1;
      @(negedge clock);
   endtask

   task automatic run_frame(input logic [7:0] len, input logic [7:0] sum,
                            input int gap_max, input bit mid_start);
      do_start();
      send_byte(len, 0);
      for (int i = 0; i < pay_q.size(); i++) begin
         if (mid_start && i == 1) begin
            rx_valid = 1'b0;
            do_start();
         end
         send_byte(pay_q[i], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
         if (i == 0) first_acc = last_acc;
      end
      send_byte(sum, 0);
      rx_valid = 1'b0;
      repeat (2) @(negedge clock);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_rx_ready"}, {31'd0, rx_ready0}, 32'd0);
      check({tag, "_mem_w_en"}, {31'd0, mem_w_en0}, 32'd0);
      check({tag, "_mem_addr0"}, {24'd0, mem_addr0}, 32'h00);
      check({tag, "_mem_addr1"}, {24'd0, mem_addr1}, 32'hFE);
      check({tag, "_mem_w_data"}, {24'd0, mem_w_data0}, 32'h00);
      check({tag, "_busy"}, {31'd0, busy0}, 32'd0);
      check({tag, "_done"}, {31'd0, done0}, 32'd0);
      check({tag, "_err"}, {31'd0, err0}, 32'd0);
      check({tag, "_cpu_hold"}, {31'd0, cpu_hold0}, 32'd1);
   endtask

   initial begin
      reset_n  = 1'b0;
      start    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'd0;
      repeat (3) @(negedge clock);
      check_reset_values("reset");
      reset_n = 1'b1;
      @(negedge clock);

      // Frame A: L=3, 11 22 33, checksum 66, back-to-back.
      clear_log();
      pay_q = '{8'h11, 8'h22, 8'h33};
      do_start();
      check("A_busy_in_len", {31'd0, busy0}, 32'd1);
      check("A_hold_in_len", {31'd0, cpu_hold0}, 32'd1);
      send_byte(8'd3, 0);
      for (int i = 0; i < 3; i++) begin
         send_byte(pay_q[i], 0);
         if (i == 0) first_acc = last_acc;
      end
      send_byte(8'h66, 0);
      rx_valid = 1'b0;
      repeat (2) @(negedge clock);
      check("A_nwrites", wa0.size(), 32'd3);
      if (wa0.size() == 3) begin
         for (int i = 0; i < 3; i++) begin
            check("A_addr", {24'd0, wa0[i]}, i);
            check("A_data", {24'd0, wd0[i]}, {24'd0, pay_q[i]});
         end
         check("A_latency", wc0[0], first_acc);
         check("A_consec1", wc0[1] - wc0[0], 32'd1);
         check("A_consec2", wc0[2] - wc0[1], 32'd1);
      end
      if (wa1.size() == 3) begin
         check("A_base_fe_addr0", {24'd0, wa1[0]}, 32'hFE);
         check("A_base_fe_addr2", {24'd0, wa1[2]}, 32'h00);
      end else check("A_base_fe_nwrites", wa1.size(), 32'd3);
      check("A_done", {31'd0, done0}, 32'd1);
      check("A_err", {31'd0, err0}, 32'd0);
      check("A_cpu_hold", {31'd0, cpu_hold0}, 32'd0);
      check("A_busy_after", {31'd0, busy0}, 32'd0);
      check("A_rx_ready_done", {31'd0, rx_ready0}, 32'd0);

      // Frame B: L=2, 01 02, checksum 04 (bad, real sum 03).
      clear_log();
      pay_q = '{8'h01, 8'h02};
      do_start();
      check("B_done_cleared", {31'd0, done0}, 32'd0);
      check("B_hold_reasserted", {31'd0, cpu_hold0}, 32'd1);
      send_byte(8'd2, 0);
      send_byte(8'h01, 0);
      send_byte(8'h02, 0);
      send_byte(8'h04, 0);
      rx_valid = 1'b0;
      repeat (2) @(negedge clock);
      check("B_nwrites", wa0.size(), 32'd2);
      check("B_err", {31'd0, err0}, 32'd1);
      check("B_done", {31'd0, done0}, 32'd0);
      check("B_cpu_hold", {31'd0, cpu_hold0}, 32'd1);

      // Frame C: L=4, random gaps, stray start mid-load; base FE wraps FE FF 00 01.
      clear_log();
      pay_q = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
      run_frame(8'd4, 8'hE6, 2, 1'b1);
      check("C_nwrites", wa0.size(), 32'd4);
      if (wa0.size() == 4) begin
         for (int i = 0; i < 4; i++) check("C_data", {24'd0, wd0[i]}, {24'd0, pay_q[i]});
      end
      if (wa1.size() == 4) begin
         check("C_fe_addr0", {24'd0, wa1[0]}, 32'hFE);
         check("C_fe_addr1", {24'd0, wa1[1]}, 32'hFF);
         check("C_fe_addr2", {24'd0, wa1[2]}, 32'h00);
         check("C_fe_addr3", {24'd0, wa1[3]}, 32'h01);
      end else check("C_fe_nwrites", wa1.size(), 32'd4);
      check("C_done", {31'd0, done0}, 32'd1);
      check("C_err", {31'd0, err0}, 32'd0);

      // Frame D: L=0 means 256 bytes 00..FF, checksum 80.
      clear_log();
      pay_q.delete();
      for (int i = 0; i < 256; i++) pay_q.push_back(i[7:0]);
      run_frame(8'd0, 8'h80, 0, 1'b0);
      check("D_nwrites", wa0.size(), 32'd256);
      if (wa0.size() == 256) begin
         check("D_last_addr", {24'd0, wa0[255]}, 32'hFF);
         check("D_last_data", {24'd0, wd0[255]}, 32'hFF);
         check("D_span", wc0[255] - wc0[0], 32'd255);
      end
      check("D_done", {31'd0, done0}, 32'd1);
      check("D_err", {31'd0, err0}, 32'd0);

      // Frame E: reset after 2 of 5 payload bytes, with a third byte offered at the reset edge.
      clear_log();
      do_start();
      send_byte(8'd5, 0);
      send_byte(8'h51, 0);
      send_byte(8'h52, 0);
      rx_data = 8'h53;
      reset_n = 1'b0;
      @(negedge clock);
      rx_valid = 1'b0;
      check_reset_values("E_reset");
      reset_n = 1'b1;
      repeat (4) @(negedge clock);
      check("E_nwrites", wa0.size(), 32'd2);
      check("E_idle_busy", {31'd0, busy0}, 32'd0);

      // Full load after the aborted one.
      clear_log();
      pay_q = '{8'h11, 8'h22, 8'h33};
      run_frame(8'd3, 8'h66, 0, 1'b0);
      check("F_nwrites", wa0.size(), 32'd3);
      check("F_done", {31'd0, done0}, 32'd1);
      check("F_cpu_hold", {31'd0, cpu_hold0}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter BASE_ADDR, default 8'h00, first instruction-memory address written.
REQ-002 clock  input  1  single system clock; all logic on rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  one-cycle pulse that begins a load; ignored unless state is IDLE or DONE.
REQ-005 rx_data  input  8  incoming byte stream from the UART receiver.
REQ-006 rx_valid  input  1  rx_data holds a byte.
REQ-007 rx_ready  output  1  loader accepts the byte this cycle; transfer occurs when rx_valid and rx_ready are both 1.
REQ-008 mem_addr  output  8  instruction-memory write address.
REQ-009 mem_w_data  output  8  instruction-memory write data.
REQ-010 mem_w_en  output  1  instruction-memory write enable, one cycle per byte.
REQ-011 cpu_hold  output  1  holds the CPU in reset while 1.
REQ-012 busy  output  1  a load is in progress.
REQ-013 done  output  1  last load completed with a good checksum.
REQ-014 err  output  1  last load failed its checksum.

Function
REQ-015 Frame format: length byte L (L=0 means 256), then L payload bytes, then one checksum byte equal to the mod-256 sum of the payload bytes.
REQ-016 FSM states: IDLE, LEN, DATA, SUM, DONE.
REQ-017 Transitions: IDLE/DONE --start--> LEN; LEN --accept--> DATA; DATA --accept of final payload byte--> SUM; SUM --accept--> DONE.
REQ-018 rx_ready = 1 in LEN, DATA and SUM; 0 in IDLE and DONE.
REQ-019 On acceptance of payload byte k (k = 0..L-1), mem_w_en = 1 on the next cycle only, with mem_addr = (BASE_ADDR + k) mod 256 and mem_w_data = that byte; write latency is exactly 1 cycle.
REQ-020 Back-to-back payload bytes on consecutive cycles produce writes on consecutive cycles without stalling.
REQ-021 The byte counter is 9 bits wide so that L=0 counts 256 bytes; mem_addr wraps from 8'hFF to 8'h00.
REQ-022 The running checksum is 8 bits and wraps mod 256; it clears on entry to LEN.
REQ-023 In SUM, on accept: checksum match sets done=1 and err=0; mismatch sets done=0 and err=1.
REQ-024 cpu_hold = 1 in LEN, DATA and SUM, and in DONE when err=1; cpu_hold = 0 only in DONE with done=1, or in IDLE after a successful load.
REQ-025 busy = 1 exactly in LEN, DATA and SUM.
REQ-026 start clears done and err on the cycle LEN is entered.
REQ-027 A start pulse arriving while busy=1 is ignored, and the current load continues unaffected.
REQ-028 mem_w_en = 0 in every cycle not covered by REQ-019.

Reset
REQ-029 When reset_n = 0 at a clock edge: state = IDLE, counter = 0, checksum = 0, rx_ready = 0, mem_w_en = 0, mem_addr = BASE_ADDR, mem_w_data = 0, busy = 0, done = 0, err = 0, cpu_hold = 1.
REQ-030 Reset mid-load aborts the load immediately; a pending write scheduled by REQ-019 is suppressed, and memory contents already written are left unchanged.

Structure
REQ-031 The FSM state encodings and the frame constants (length-zero-means-256, checksum width) are defined in a shared package used by the loader and its testbench.
REQ-032 The block is one module with no sub-modules; it drives the write port of the existing instruction memory directly, and the memory's read port stays with the CPU.

Verification
REQ-033 Frame L=3, payload 11,22,33, checksum 66, back-to-back bytes -> writes at addresses 00,01,02 on consecutive cycles; done=1, err=0, cpu_hold falls to 0.
REQ-034 Frame L=2, payload 01,02, checksum 04 -> both bytes written; err=1, done=0, cpu_hold remains 1.
REQ-035 BASE_ADDR=8'hFE, L=4 -> writes at addresses FE, FF, 00, 01.
REQ-036 L=0 followed by 256 bytes and a correct checksum -> exactly 256 mem_w_en pulses, then done=1.
REQ-037 rx_valid toggled randomly during DATA -> one write per accepted byte only; start pulsed mid-load has no effect.
REQ-038 reset_n pulled low after 2 of 5 payload bytes -> no further writes; all outputs at their reset values; a subsequent full load completes normally.
